// File: rtl/hw3proc_key_pio.sv
// Avalon-MM input PIO: synchronizes external key/switch lines, latches per-bit
// edges in a write-1-to-clear capture register and raises a maskable level irq.
module hw3proc_key_pio #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int         EDGE_RISE = 0;
    localparam int         EDGE_FALL = 1;
    localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] edgecapture_r;
    logic [2:0]       arm_cnt_r;
    logic [31:0]      readdata_r;

    logic             wr_s;
    logic             armed_s;
    logic [WIDTH-1:0] sync_q_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] edge_sel_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] edgecapture_next_s;
    logic [31:0]      rd_mux_s;
    logic             unused_s;

    assign wr_s     = chipselect & ~write_n;
    assign armed_s  = (arm_cnt_r == ARM_COUNT);
    assign sync_q_s = sync_r[SYNC_STAGES-1];
    assign rise_s   = sync_q_s & ~prev_r;
    assign fall_s   = ~sync_q_s & prev_r;
    assign unused_s = ^writedata;

    // Synchronizer chain and one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
            prev_r <= '0;
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= sync_q_s;
        end
    end

    // Arm counter: holds off capture until the reset-level sync flops have flushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_r <= 3'd0;
        end else if (!armed_s) begin
            arm_cnt_r <= arm_cnt_r + 3'd1;
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    // Edge polarity selection.
    always_comb begin
        edge_sel_s = rise_s | fall_s;
        case (EDGE_TYPE)
            EDGE_RISE: edge_sel_s = rise_s;
            EDGE_FALL: edge_sel_s = fall_s;
            default:   edge_sel_s = rise_s | fall_s;
        endcase
    end

    // Capture update: write-1-to-clear, with a new edge taking priority over the clear.
    always_comb begin
        clr_s = '0;
        set_s = '0;
        if (wr_s && (address == 2'd3)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = '0;
        end
        if (armed_s) begin
            set_s = edge_sel_s;
        end else begin
            set_s = '0;
        end
        edgecapture_next_s = (edgecapture_r & ~clr_s) | set_s;
    end

    // Interrupt mask and edge-capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_r     <= '0;
            edgecapture_r <= '0;
        end else begin
            if (wr_s && (address == 2'd2)) begin
                irqmask_r <= writedata[WIDTH-1:0];
            end else begin
                irqmask_r <= irqmask_r;
            end
            edgecapture_r <= edgecapture_next_s;
        end
    end

    // Read address mux, zero-extended to the bus width.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            2'd0:    rd_mux_s[WIDTH-1:0] = sync_q_s;
            2'd1:    rd_mux_s = 32'd0;
            2'd2:    rd_mux_s[WIDTH-1:0] = irqmask_r;
            2'd3:    rd_mux_s[WIDTH-1:0] = edgecapture_r;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, zero whenever the slave is not selected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else if (chipselect) begin
            readdata_r <= rd_mux_s;
        end else begin
            readdata_r <= 32'd0;
        end
    end

    assign readdata = readdata_r;
    assign irq      = |(edgecapture_r & irqmask_r);

endmodule

// File: tb/tb_hw3proc_key_pio.sv
// Scoreboard bench for hw3proc_key_pio: a falling-edge instance and an any-edge
// instance share the bus; reads queue expected data that per-instance monitors check.
module tb_hw3proc_key_pio;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        cs1;
    logic        cs2;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in1;
    logic [3:0]  in2;
    logic [31:0] readdata1;
    logic [31:0] readdata2;
    logic        irq1;
    logic        irq2;

    int compared   = 0;
    int mismatched = 0;
    exp_t exp1_q[$];
    exp_t exp2_q[$];
    logic rd1_r = 1'b0;
    logic rd2_r = 1'b0;

    hw3proc_key_pio #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(readdata1), .irq(irq1)
    );

    hw3proc_key_pio #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(readdata2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // A read is in flight when the slave was selected for reading at the edge.
    always @(posedge clk) begin
        rd1_r <= cs1 && write_n;
        rd2_r <= cs2 && write_n;
    end

    // Monitor: read data of a sampled read is valid at the following falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rd1_r) begin
            if (exp1_q.size() == 0) begin
                check("dut1_unexpected_read", readdata1, 32'hxxxx_xxxx);
            end else begin
                e = exp1_q.pop_front();
                check(e.name, readdata1, e.value);
            end
        end
        if (rd2_r) begin
            if (exp2_q.size() == 0) begin
                check("dut2_unexpected_read", readdata2, 32'hxxxx_xxxx);
            end else begin
                e = exp2_q.pop_front();
                check(e.name, readdata2, e.value);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic rd(input int d, input logic [1:0] a, input logic [31:0] v, input string n);
        exp_t e;
        e.name  = n;
        e.value = v;
        address = a;
        write_n = 1'b1;
        if (d == 1) begin
            cs1 = 1'b1;
            exp1_q.push_back(e);
        end else begin
            cs2 = 1'b1;
            exp2_q.push_back(e);
        end
        tick(1);
        cs1 = 1'b0;
        cs2 = 1'b0;
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
        address   = a;
        writedata = v;
        write_n   = 1'b0;
        if (d == 1) cs1 = 1'b1;
        else        cs2 = 1'b1;
        tick(1);
        cs1     = 1'b0;
        cs2     = 1'b0;
        write_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        reset_n   = 1'b0;
        address   = 2'd0;
        cs1       = 1'b0;
        cs2       = 1'b0;
        write_n   = 1'b1;
        writedata = 32'd0;
        in1       = 4'hF;
        in2       = 4'hF;
        @(negedge clk);
        tick(2);
        check("reset_readdata", readdata1, 32'd0);
        check("reset_irq", {31'd0, irq1}, 32'd0);
        reset_n = 1'b1;
        tick(6);

        // 1: idle-high inputs after arming give no false edge
        rd(1, 2'd0, 32'h0000_000F, "t1_data");
        rd(1, 2'd3, 32'h0000_0000, "t1_edgecap");
        rd(1, 2'd1, 32'h0000_0000, "t1_addr1");
        check("t1_irq", {31'd0, irq1}, 32'd0);

        // 2: bit0 falls; capture two edges after the first sampling edge
        in1 = 4'hE;
        tick(2);
        rd(1, 2'd3, 32'h0000_0000, "t2_edgecap_before");
        rd(1, 2'd3, 32'h0000_0001, "t2_edgecap_after");
        rd(1, 2'd0, 32'h0000_000E, "t2_data");
        check("t2_irq_masked", {31'd0, irq1}, 32'd0);
        wr(1, 2'd2, 32'h0000_0001);
        check("t2_irq_unmasked", {31'd0, irq1}, 32'd1);
        rd(1, 2'd2, 32'h0000_0001, "t2_mask");

        // 3: write-1-to-clear leaves zero bits alone
        in1 = 4'hA;
        tick(4);
        rd(1, 2'd3, 32'h0000_0005, "t3_edgecap");
        wr(1, 2'd3, 32'h0000_0004);
        rd(1, 2'd3, 32'h0000_0001, "t3_partial_clear");
        check("t3_irq_still", {31'd0, irq1}, 32'd1);
        wr(1, 2'd3, 32'h0000_0001);
        check("t3_irq_drop", {31'd0, irq1}, 32'd0);
        rd(1, 2'd3, 32'h0000_0000, "t3_cleared");

        // 4: rising edge ignored; edge and clear on the same cycle keeps the bit
        in1 = 4'hE;
        tick(4);
        rd(1, 2'd3, 32'h0000_0000, "t4_rise_ignored");
        in1 = 4'hA;
        tick(2);
        wr(1, 2'd3, 32'h0000_0004);
        rd(1, 2'd3, 32'h0000_0004, "t4_set_wins");
        wr(1, 2'd3, 32'h0000_0004);
        rd(1, 2'd3, 32'h0000_0000, "t4_cleared");

        // 5: short and 3-clk low pulses on bit3 of the falling-edge instance
        in1 = 4'h2;
        tick(1);
        in1 = 4'hA;
        tick(4);
        wr(1, 2'd3, 32'h0000_000F);
        rd(1, 2'd3, 32'h0000_0000, "t5_clear");
        in1 = 4'h2;
        tick(3);
        in1 = 4'hA;
        tick(4);
        rd(1, 2'd3, 32'h0000_0008, "t5_pulse3");
        wr(1, 2'd3, 32'h0000_0008);
        tick(2);
        rd(1, 2'd3, 32'h0000_0000, "t5_no_rise");

        // 5b: any-edge instance sees both edges of a 3-clk pulse
        rd(2, 2'd3, 32'h0000_0000, "t5b_idle");
        in2 = 4'h7;
        tick(3);
        in2 = 4'hF;
        rd(2, 2'd3, 32'h0000_0008, "t5b_fall");
        wr(2, 2'd3, 32'h0000_0008);
        rd(2, 2'd3, 32'h0000_0000, "t5b_cleared");
        tick(2);
        rd(2, 2'd3, 32'h0000_0008, "t5b_rise");

        // 6: asynchronous reset while irq is high
        wr(1, 2'd2, 32'hFFFF_FFFF);
        rd(1, 2'd2, 32'h0000_000F, "t6_mask_width");
        in1 = 4'h8;
        tick(4);
        check("t6_irq_pre", {31'd0, irq1}, 32'd1);
        address = 2'd2;
        cs1     = 1'b1;
        e.name  = "t6_rd_in_reset";
        e.value = 32'd0;
        exp1_q.push_back(e);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_readdata", readdata1, 32'd0);
        check("t6_rst_irq", {31'd0, irq1}, 32'd0);
        @(negedge clk);
        cs1 = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(6);
        rd(1, 2'd2, 32'h0000_0000, "t6_mask_cleared");
        rd(1, 2'd3, 32'h0000_0000, "t6_edgecap_cleared");
        check("t6_irq_after", {31'd0, irq1}, 32'd0);
        wr(1, 2'd0, 32'hFFFF_FFFF);
        wr(1, 2'd1, 32'hFFFF_FFFF);
        rd(1, 2'd1, 32'h0000_0000, "t6_addr1");
        rd(1, 2'd0, 32'h0000_0008, "t6_data");
        rd(1, 2'd2, 32'h0000_0000, "t6_mask_untouched");
        tick(1);
        check("t6_cs_low_readdata", readdata1, 32'd0);

        tick(2);
        check("queue1_drained", exp1_q.size(), 32'd0);
        check("queue2_drained", exp2_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
